network_link_buffered: RTL and testbench

- Parametrised successor to the combinational mesh/torus interconnect.
- Wires X_NODES×Y_NODES routers (5 ports each: 0=N, 1=E, 2=S, 3=W, 4=local) in mesh or torus mode.
- Every inter-router link gets a registered LINK_DEPTH-entry FIFO with write/hold flow control.
- Adds per-link sticky overflow flags and a mesh-edge hold tie-off; sits between router instances and node interfaces at network top level.

---
 rtl/network_link_buffered.sv | 140 ++++++++++++++
 tb/tb_network_link_buffered.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/network_link_buffered.sv
// rtl/network_link_buffered.sv - Mesh/torus link fabric with a registered FIFO on every router-to-router link
module network_link_buffered #(
    parameter int X_NODES    = 4,
    parameter int Y_NODES    = 4,
    parameter int FIFO_WIDTH = 64,
    parameter int LINK_DEPTH = 2,
    parameter int MODE       = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [FIFO_WIDTH-1:0] routerOutData [X_NODES*Y_NODES][5],
    input  logic                  routerOutWrite [X_NODES*Y_NODES][5],
    input  logic                  routerInHold [X_NODES*Y_NODES][5],
    output logic [FIFO_WIDTH-1:0] routerInData [X_NODES*Y_NODES][5],
    output logic                  routerInWrite [X_NODES*Y_NODES][5],
    output logic                  routerOutHold [X_NODES*Y_NODES][5],
    input  logic [FIFO_WIDTH-1:0] nodeToNetworkData [X_NODES*Y_NODES],
    input  logic                  nodeToNetworkWriteRequest [X_NODES*Y_NODES],
    input  logic                  nodeToNetworkHoldRequest [X_NODES*Y_NODES],
    output logic [FIFO_WIDTH-1:0] networkToNodeData [X_NODES*Y_NODES],
    output logic                  networkToNodeWriteRequest [X_NODES*Y_NODES],
    output logic                  networkToNodeHoldRequest [X_NODES*Y_NODES],
    output logic                  linkOverflow [X_NODES*Y_NODES][4]
);
    localparam int N  = X_NODES * Y_NODES;
    localparam int CW = $clog2(LINK_DEPTH + 1);
    localparam int PW = (LINK_DEPTH > 1) ? $clog2(LINK_DEPTH) : 1;

    // Node reached from n through output port p (0=N, 1=E, 2=S, 3=W), wrapping within row/column.
    function automatic int neighbour(int n, int p);
        int x;
        int y;
        x = n % X_NODES;
        y = n / X_NODES;
        case (p)
            0:       y = (y + 1) % Y_NODES;
            1:       x = (x + 1) % X_NODES;
            2:       y = (y + Y_NODES - 1) % Y_NODES;
            default: x = (x + X_NODES - 1) % X_NODES;
        endcase
        return x + X_NODES * y;
    endfunction

    // In mesh mode a port pointing off the grid has no partner; links are symmetric so this also
    // tells whether input p of node n has a source.
    function automatic bit linkExists(int n, int p);
        int x;
        int y;
        x = n % X_NODES;
        y = n / X_NODES;
        if (MODE == 1) return 1'b1;
        case (p)
            0:       return y != Y_NODES - 1;
            1:       return x != X_NODES - 1;
            2:       return y != 0;
            default: return x != 0;
        endcase
    endfunction

    function automatic logic [PW-1:0] bumpPtr(logic [PW-1:0] ptr);
        return (ptr == PW'(LINK_DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    logic [FIFO_WIDTH-1:0] linkHead [N][4];
    logic                  linkValid [N][4];
    logic                  linkFull [N][4];
    logic                  linkOvf [N][4];

    for (genvar n = 0; n < N; n++) begin : gNode
        for (genvar p = 0; p < 4; p++) begin : gPort
            if (linkExists(n, p)) begin : gLink
                localparam int DST = neighbour(n, p);
                localparam int OPP = (p + 2) % 4;

                logic [FIFO_WIDTH-1:0] mem [LINK_DEPTH];
                logic [PW-1:0]         wrPtr;
                logic [PW-1:0]         rdPtr;
                logic [CW-1:0]         count;
                logic                  overflow;
                logic                  full;
                logic                  push;
                logic                  pop;

                assign full = (count == CW'(LINK_DEPTH));
                assign push = routerOutWrite[n][p] && !full;
                assign pop  = (count != '0) && !routerInHold[DST][OPP];

                always_ff @(posedge clk) begin
                    if (push) mem[wrPtr] <= routerOutData[n][p];
                end

                // A write arriving while full is lost even if a pop frees a slot on the same edge.
                always_ff @(posedge clk or posedge reset) begin
                    if (reset) begin
                        wrPtr    <= '0;
                        rdPtr    <= '0;
                        count    <= '0;
                        overflow <= 1'b0;
                    end else begin
                        if (push) wrPtr <= bumpPtr(wrPtr);
                        if (pop)  rdPtr <= bumpPtr(rdPtr);
                        count <= count + CW'(push) - CW'(pop);
                        if (routerOutWrite[n][p] && full) overflow <= 1'b1;
                    end
                end

                assign linkHead[n][p]  = (count != '0) ? mem[rdPtr] : '0;
                assign linkValid[n][p] = (count != '0);
                assign linkFull[n][p]  = full;
                assign linkOvf[n][p]   = overflow;
            end else begin : gEdge
                assign linkHead[n][p]  = '0;
                assign linkValid[n][p] = 1'b0;
                assign linkFull[n][p]  = 1'b1;
                assign linkOvf[n][p]   = 1'b0;
            end
        end
    end

    always_comb begin
        for (int n = 0; n < N; n++) begin
            for (int p = 0; p < 4; p++) begin
                routerOutHold[n][p] = linkFull[n][p];
                linkOverflow[n][p]  = linkOvf[n][p];
                routerInData[n][p]  = '0;
                routerInWrite[n][p] = 1'b0;
                if (linkExists(n, p)) begin
                    routerInData[n][p]  = linkHead[neighbour(n, p)][(p + 2) % 4];
                    routerInWrite[n][p] = linkValid[neighbour(n, p)][(p + 2) % 4];
                end
            end
            routerInData[n][4]           = nodeToNetworkData[n];
            routerInWrite[n][4]          = nodeToNetworkWriteRequest[n];
            routerOutHold[n][4]          = nodeToNetworkHoldRequest[n];
            networkToNodeData[n]         = routerOutData[n][4];
            networkToNodeWriteRequest[n] = routerOutWrite[n][4];
            networkToNodeHoldRequest[n]  = routerInHold[n][4];
        end
    end
endmodule

// File: tb/tb_network_link_buffered.sv
// tb/tb_network_link_buffered.sv - Self-checking bench: 3x3 torus (depth 2) and 3x3 mesh (depth 3) against a queue model
module tb_network_link_buffered;
    localparam int XN = 3;
    localparam int YN = 3;
    localparam int N  = XN * YN;
    localparam int W  = 16;
    localparam int L  = N * 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [W-1:0] routerOutData [N][5];
    logic         routerOutWrite [N][5];
    logic         routerInHold [N][5];
    logic [W-1:0] nodeToNetworkData [N];
    logic         nodeToNetworkWriteRequest [N];
    logic         nodeToNetworkHoldRequest [N];

    logic [W-1:0] inDataT [N][5], inDataM [N][5];
    logic         inWriteT [N][5], inWriteM [N][5];
    logic         outHoldT [N][5], outHoldM [N][5];
    logic [W-1:0] ejDataT [N], ejDataM [N];
    logic         ejWriteT [N], ejWriteM [N];
    logic         ejHoldT [N], ejHoldM [N];
    logic         ovfT [N][4], ovfM [N][4];

    network_link_buffered #(.X_NODES(XN), .Y_NODES(YN), .FIFO_WIDTH(W), .LINK_DEPTH(2), .MODE(1)) dutT (
        .clk(clk), .reset(reset),
        .routerOutData(routerOutData), .routerOutWrite(routerOutWrite), .routerInHold(routerInHold),
        .routerInData(inDataT), .routerInWrite(inWriteT), .routerOutHold(outHoldT),
        .nodeToNetworkData(nodeToNetworkData), .nodeToNetworkWriteRequest(nodeToNetworkWriteRequest),
        .nodeToNetworkHoldRequest(nodeToNetworkHoldRequest),
        .networkToNodeData(ejDataT), .networkToNodeWriteRequest(ejWriteT),
        .networkToNodeHoldRequest(ejHoldT), .linkOverflow(ovfT)
    );

    network_link_buffered #(.X_NODES(XN), .Y_NODES(YN), .FIFO_WIDTH(W), .LINK_DEPTH(3), .MODE(0)) dutM (
        .clk(clk), .reset(reset),
        .routerOutData(routerOutData), .routerOutWrite(routerOutWrite), .routerInHold(routerInHold),
        .routerInData(inDataM), .routerInWrite(inWriteM), .routerOutHold(outHoldM),
        .nodeToNetworkData(nodeToNetworkData), .nodeToNetworkWriteRequest(nodeToNetworkWriteRequest),
        .nodeToNetworkHoldRequest(nodeToNetworkHoldRequest),
        .networkToNodeData(ejDataM), .networkToNodeWriteRequest(ejWriteM),
        .networkToNodeHoldRequest(ejHoldM), .linkOverflow(ovfM)
    );

    int testsRun    = 0;
    int testsFailed = 0;

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: one flit queue per (instance, node, port) plus a sticky overflow bit.
    logic [W-1:0] mq [2*L][$];
    bit           mOvf [2*L];

    function automatic int depthOf(int inst);
        return (inst == 0) ? 2 : 3;
    endfunction

    function automatic bit hasLink(int inst, int n, int p);
        int x;
        int y;
        x = n % XN;
        y = n / XN;
        if (inst == 0) return 1'b1;
        return !((p == 0 && y == YN - 1) || (p == 1 && x == XN - 1) || (p == 2 && y == 0) || (p == 3 && x == 0));
    endfunction

    function automatic int dest(int n, int p);
        int x;
        int y;
        x = n % XN;
        y = n / XN;
        if (p == 0) y = (y + 1) % YN;
        else if (p == 1) x = (x + 1) % XN;
        else if (p == 2) y = (y + YN - 1) % YN;
        else x = (x + XN - 1) % XN;
        return y * XN + x;
    endfunction

    function automatic string tag(string s, int inst, int n, int p);
        return $sformatf("%s.%s[%0d][%0d]", (inst == 0) ? "torus" : "mesh", s, n, p);
    endfunction

    function automatic logic [W-1:0] obsInData(int inst, int n, int p);
        return (inst == 0) ? inDataT[n][p] : inDataM[n][p];
    endfunction
    function automatic logic obsInWrite(int inst, int n, int p);
        return (inst == 0) ? inWriteT[n][p] : inWriteM[n][p];
    endfunction
    function automatic logic obsOutHold(int inst, int n, int p);
        return (inst == 0) ? outHoldT[n][p] : outHoldM[n][p];
    endfunction
    function automatic logic obsOvf(int inst, int n, int p);
        return (inst == 0) ? ovfT[n][p] : ovfM[n][p];
    endfunction

    task automatic clearModel();
        for (int k = 0; k < 2 * L; k++) begin
            mq[k].delete();
            mOvf[k] = 1'b0;
        end
    endtask

    task automatic checkOutputs(input int inst);
        for (int n = 0; n < N; n++) begin
            for (int p = 0; p < 4; p++) begin
                int k;
                int sz;
                logic [W-1:0] head;
                k    = inst * L + n * 4 + p;
                sz   = mq[k].size();
                head = '0;
                if (sz > 0) head = mq[k][0];
                if (hasLink(inst, n, p)) begin
                    checkVal(tag("outHold", inst, n, p), obsOutHold(inst, n, p), sz == depthOf(inst));
                    checkVal(tag("overflow", inst, n, p), obsOvf(inst, n, p), mOvf[k]);
                    checkVal(tag("inWrite", inst, dest(n, p), (p + 2) % 4),
                             obsInWrite(inst, dest(n, p), (p + 2) % 4), sz > 0);
                    checkVal(tag("inData", inst, dest(n, p), (p + 2) % 4),
                             obsInData(inst, dest(n, p), (p + 2) % 4), head);
                end else begin
                    checkVal(tag("edgeHold", inst, n, p), obsOutHold(inst, n, p), 1);
                    checkVal(tag("edgeOverflow", inst, n, p), obsOvf(inst, n, p), 0);
                    checkVal(tag("edgeInWrite", inst, n, p), obsInWrite(inst, n, p), 0);
                    checkVal(tag("edgeInData", inst, n, p), obsInData(inst, n, p), 0);
                end
            end
            checkVal(tag("localInData", inst, n, 4), obsInData(inst, n, 4), nodeToNetworkData[n]);
            checkVal(tag("localInWrite", inst, n, 4), obsInWrite(inst, n, 4), nodeToNetworkWriteRequest[n]);
            checkVal(tag("localOutHold", inst, n, 4), obsOutHold(inst, n, 4), nodeToNetworkHoldRequest[n]);
            checkVal(tag("ejData", inst, n, 4), (inst == 0) ? ejDataT[n] : ejDataM[n], routerOutData[n][4]);
            checkVal(tag("ejWrite", inst, n, 4), (inst == 0) ? ejWriteT[n] : ejWriteM[n], routerOutWrite[n][4]);
            checkVal(tag("ejHold", inst, n, 4), (inst == 0) ? ejHoldT[n] : ejHoldM[n], routerInHold[n][4]);
        end
    endtask

    task automatic modelStep(input int inst);
        for (int n = 0; n < N; n++) begin
            for (int p = 0; p < 4; p++) begin
                int k;
                int sz;
                if (hasLink(inst, n, p)) begin
                    k  = inst * L + n * 4 + p;
                    sz = mq[k].size();
                    if (routerOutWrite[n][p] && sz == depthOf(inst)) mOvf[k] = 1'b1;
                    if (sz > 0 && !routerInHold[dest(n, p)][(p + 2) % 4]) void'(mq[k].pop_front());
                    if (routerOutWrite[n][p] && sz < depthOf(inst)) mq[k].push_back(routerOutData[n][p]);
                end
            end
        end
    endtask

    // Called just after a falling edge with inputs applied; returns at the next falling edge.
    task automatic cycle();
        #1;
        checkOutputs(0);
        checkOutputs(1);
        if (!reset) begin
            modelStep(0);
            modelStep(1);
        end
        @(negedge clk);
    endtask

    task automatic clearInputs();
        for (int n = 0; n < N; n++) begin
            for (int p = 0; p < 5; p++) begin
                routerOutData[n][p]  = '0;
                routerOutWrite[n][p] = 1'b0;
                routerInHold[n][p]   = 1'b0;
            end
            nodeToNetworkData[n]         = '0;
            nodeToNetworkWriteRequest[n] = 1'b0;
            nodeToNetworkHoldRequest[n]  = 1'b0;
        end
    endtask

    task automatic randomInputs(input int wrPct, input int holdPct, input bit honour);
        for (int n = 0; n < N; n++) begin
            for (int p = 0; p < 5; p++) begin
                routerOutData[n][p]  = W'($urandom);
                routerOutWrite[n][p] = ($urandom_range(99) < wrPct) && !(honour && p < 4 && outHoldT[n][p]);
                routerInHold[n][p]   = ($urandom_range(99) < holdPct);
            end
            nodeToNetworkData[n]         = W'($urandom);
            nodeToNetworkWriteRequest[n] = $urandom_range(1) == 1;
            nodeToNetworkHoldRequest[n]  = $urandom_range(1) == 1;
        end
    endtask

    task automatic assertReset();
        reset = 1'b1;
        #1;
        clearModel();
    endtask

    task automatic checkMeshEdgeHolds(input string when);
        checkVal({when, ".meshHold[2][1]"}, outHoldM[2][1], 1);
        checkVal({when, ".meshHold[0][3]"}, outHoldM[0][3], 1);
        checkVal({when, ".meshHold[6][0]"}, outHoldM[6][0], 1);
        checkVal({when, ".meshHold[0][2]"}, outHoldM[0][2], 1);
    endtask

    int wrPct [5]   = '{30, 60, 90, 100, 95};
    int holdPct [5] = '{10, 40, 70, 0, 30};
    bit honour [5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    initial begin
        clearModel();
        clearInputs();
        @(negedge clk);

        // Reset held with random traffic: nothing may be captured, mesh edges stay held.
        for (int i = 0; i < 3; i++) begin
            randomInputs(80, 20, 1'b0);
            #1;
            checkMeshEdgeHolds("reset");
            cycle();
        end
        clearInputs();
        reset = 1'b0;
        cycle();

        // Single flit, one cycle latency, gone the cycle after.
        routerOutData[0][1] = 16'h00A5;
        routerOutWrite[0][1] = 1'b1;
        cycle();
        clearInputs();
        #1;
        checkVal("a5.inWrite[1][3]", inWriteT[1][3], 1);
        checkVal("a5.inData[1][3]", inDataT[1][3], 16'h00A5);
        cycle();
        checkVal("a5.drained", inWriteT[1][3], 0);
        cycle();

        // Fill against downstream hold, overflow on third write, then drain in order.
        routerInHold[1][3] = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            routerOutData[0][1]  = W'(i);
            routerOutWrite[0][1] = 1'b1;
            if (i == 3) begin
                #1;
                checkVal("ovf.holdAtThird", outHoldT[0][1], 1);
                checkVal("ovf.notYetSet", ovfT[0][1], 0);
            end
            cycle();
        end
        routerOutWrite[0][1] = 1'b0;
        routerInHold[1][3]   = 1'b0;
        #1;
        checkVal("ovf.sticky", ovfT[0][1], 1);
        checkVal("ovf.first", inDataT[1][3], 16'h0001);
        cycle();
        checkVal("ovf.second", inDataT[1][3], 16'h0002);
        checkVal("ovf.stillSet", ovfT[0][1], 1);
        cycle();
        checkVal("ovf.empty", inWriteT[1][3], 0);
        cycle();

        // Torus wrap-around links.
        routerOutData[2][1] = 16'h0077;
        routerOutWrite[2][1] = 1'b1;
        routerOutData[6][0] = 16'h0055;
        routerOutWrite[6][0] = 1'b1;
        cycle();
        clearInputs();
        #1;
        checkVal("wrap.east", inDataT[0][3], 16'h0077);
        checkVal("wrap.north", inDataT[0][2], 16'h0055);
        checkVal("wrap.meshWest", inWriteM[0][3], 0);
        cycle();

        // Asynchronous reset with two flits buffered.
        routerInHold[5][3] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            routerOutData[4][1]  = W'(16'h0B00 + i);
            routerOutWrite[4][1] = 1'b1;
            cycle();
        end
        routerOutWrite[4][1] = 1'b0;
        #1;
        checkVal("rst.bufferedFull", outHoldT[4][1], 1);
        assertReset();
        checkVal("rst.inWriteAsync", inWriteT[5][3], 0);
        checkVal("rst.inDataAsync", inDataT[5][3], 0);
        checkVal("rst.holdAsync", outHoldT[4][1], 0);
        checkVal("rst.ovfAsync", ovfT[0][1], 0);
        cycle();
        clearInputs();
        reset = 1'b0;
        cycle();
        checkVal("rst.noStale", inWriteT[5][3], 0);
        cycle();

        // Randomized segments separated by mid-cycle resets.
        for (int s = 0; s < 5; s++) begin
            for (int i = 0; i < 150; i++) begin
                randomInputs(wrPct[s], holdPct[s], honour[s]);
                cycle();
            end
            if (honour[s]) begin
                int anyOvf;
                anyOvf = 0;
                for (int n = 0; n < N; n++)
                    for (int p = 0; p < 4; p++)
                        anyOvf += int'(ovfT[n][p]);
                checkVal($sformatf("honour%0d.noOverflow", s), anyOvf, 0);
            end
            randomInputs(50, 50, 1'b0);
            assertReset();
            checkMeshEdgeHolds("midReset");
            cycle();
            reset = 1'b0;
        end
        clearInputs();
        cycle();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
